// File: rtl/clb_pkg.sv
// Shared definitions for the parametrised configurable logic block:
// configuration FSM state type and helpers that derive the config-field
// widths from the block parameters.
package clb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } clb_state_t;

  // Width of one LUT input-select field: max(1, clog2(num_in)).
  function automatic int unsigned clb_sw(input int unsigned num_in);
    int unsigned w;
    w = $clog2(num_in);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of one output-select field: max(1, clog2(num_lut)).
  function automatic int unsigned clb_ow(input int unsigned num_lut);
    int unsigned w;
    w = $clog2(num_lut);
    return (w < 1) ? 1 : w;
  endfunction

  // Bits per LUT field: selects + truth-table mask + ff_en + ff_init.
  function automatic int unsigned clb_lf(input int unsigned lut_k,
                                         input int unsigned sw);
    return lut_k * sw + (32'd1 << lut_k) + 2;
  endfunction

  // Total serial configuration length.
  function automatic int unsigned clb_cfg_bits(input int unsigned num_in,
                                               input int unsigned lut_k,
                                               input int unsigned num_lut,
                                               input int unsigned num_out);
    return num_lut * clb_lf(lut_k, clb_sw(num_in)) + num_out * clb_ow(num_lut);
  endfunction

endpackage

// File: rtl/clb_lut.sv
// clb_lut: purely combinational LUT_K-input lookup table.
// Ports:
//   i_mask  [2^LUT_K]  truth table, bit i is the output for input code i
//   i_in    [LUT_K]    input vector (bit 0 is the LSB of the table index)
//   o_f     [1]        selected truth-table bit
module clb_lut #(
  parameter int unsigned LUT_K = 3
) (
  input  logic [(1 << LUT_K)-1:0] i_mask,
  input  logic [LUT_K-1:0]        i_in,
  output logic                    o_f
);

  assign o_f = i_mask[i_in];

endmodule

// File: rtl/clb_param.sv
// clb_param: parametrised configurable logic block. NUM_LUT LUTs pick their
// inputs from the registered primary inputs, each optionally followed by a
// flip-flop; NUM_OUT outputs each pick one LUT stage. Configuration is
// loaded serially into a shadow register and transferred atomically to the
// active configuration on a successful commit, so the running logic never
// sees a partially loaded setup.
// Ports:
//   clk         sole clock, rising edge
//   reset_n     synchronous active-low reset
//   din         primary logic inputs (registered every cycle)
//   ce          clock enable for the LUT flip-flops
//   cfg_en      shift one configuration bit this cycle
//   cfg_din     serial configuration data
//   cfg_commit  request shadow-to-active transfer
//   cfg_dout    shadow MSB, for daisy-chaining blocks
//   cfg_valid   an active configuration has been loaded
//   cfg_err     sticky: commit attempted with an incomplete load
//   dout        logic outputs
module clb_param
  import clb_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned LUT_K   = 3,
  parameter int unsigned NUM_LUT = 2,
  parameter int unsigned NUM_OUT = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IN-1:0]  din,
  input  logic               ce,
  input  logic               cfg_en,
  input  logic               cfg_din,
  input  logic               cfg_commit,
  output logic               cfg_dout,
  output logic               cfg_valid,
  output logic               cfg_err,
  output logic [NUM_OUT-1:0] dout
);

  localparam int unsigned SW       = clb_sw(NUM_IN);
  localparam int unsigned OW       = clb_ow(NUM_LUT);
  localparam int unsigned LF       = clb_lf(LUT_K, SW);
  localparam int unsigned CFG_BITS = clb_cfg_bits(NUM_IN, LUT_K, NUM_LUT, NUM_OUT);
  localparam int unsigned MW       = 32'd1 << LUT_K;
  localparam int unsigned SELW     = LUT_K * SW;
  localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);
  localparam int unsigned DPAD     = 32'd1 << SW;
  localparam int unsigned SPAD     = 32'd1 << OW;
  localparam int unsigned OUT_BASE = NUM_LUT * LF;

  // Configuration load state
  clb_state_t              r_state;
  logic [CFG_BITS-1:0]     r_shadow;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_valid;
  logic                    r_err;

  // Active configuration (ff_init is only needed at commit time)
  logic [NUM_LUT-1:0][SELW-1:0] r_act_sel;
  logic [NUM_LUT-1:0][MW-1:0]   r_act_mask;
  logic [NUM_LUT-1:0]           r_act_ffen;
  logic [NUM_OUT-1:0][OW-1:0]   r_act_osel;

  // Datapath registers
  logic [NUM_IN-1:0]       r_din_q;
  logic [NUM_LUT-1:0]      r_ff;

  // Shadow register fields, decoded for the commit transfer
  logic [NUM_LUT-1:0][SELW-1:0] w_sh_sel;
  logic [NUM_LUT-1:0][MW-1:0]   w_sh_mask;
  logic [NUM_LUT-1:0]           w_sh_ffen;
  logic [NUM_LUT-1:0]           w_sh_init;
  logic [NUM_OUT-1:0][OW-1:0]   w_sh_osel;

  logic                    w_cnt_full;
  logic                    w_commit_ok;
  logic [DPAD-1:0]         w_din_pad;
  logic [NUM_LUT-1:0]      w_f;
  logic [NUM_LUT-1:0]      w_stage;
  logic [SPAD-1:0]         w_stage_pad;

  assign w_cnt_full  = (r_cnt == CNT_W'(CFG_BITS));
  assign w_commit_ok = cfg_commit && (r_state == ST_LOAD) && w_cnt_full;

  // Decode the shadow register into its per-LUT and per-output fields
  for (genvar j = 0; j < NUM_LUT; j++) begin : g_sh_lut
    assign w_sh_sel[j]  = r_shadow[j*LF +: SELW];
    assign w_sh_mask[j] = r_shadow[j*LF + SELW +: MW];
    assign w_sh_ffen[j] = r_shadow[j*LF + SELW + MW];
    assign w_sh_init[j] = r_shadow[j*LF + LF - 1];
  end

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_sh_out
    assign w_sh_osel[n] = r_shadow[OUT_BASE + n*OW +: OW];
  end

  // Configuration FSM: serial shift, load counting and commit/abort.
  // A commit is judged on the pre-shift count; a same-cycle cfg_en still
  // shifts and restarts the load with the count at one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_shadow   <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_act_sel  <= '0;
      r_act_mask <= '0;
      r_act_ffen <= '0;
      r_act_osel <= '0;
    end else begin
      if (cfg_commit) begin
        if (w_commit_ok) begin
          r_act_sel  <= w_sh_sel;
          r_act_mask <= w_sh_mask;
          r_act_ffen <= w_sh_ffen;
          r_act_osel <= w_sh_osel;
          r_valid    <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end else if (cfg_en && (r_state == ST_IDLE)) begin
        r_err <= 1'b0;
      end

      if (cfg_en) begin
        r_shadow <= {r_shadow[CFG_BITS-2:0], cfg_din};
        if ((r_state == ST_IDLE) || cfg_commit) begin
          r_state <= ST_LOAD;
          r_cnt   <= CNT_W'(1);
        end else if (!w_cnt_full) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (cfg_commit) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end
    end
  end

  // Input stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_din_q <= '0;
    end else begin
      r_din_q <= din;
    end
  end

  // LUT flip-flops: preset from ff_init on commit, else follow f when enabled
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ff <= '0;
    end else begin
      for (int j = 0; j < NUM_LUT; j++) begin
        if (w_commit_ok) begin
          r_ff[j] <= w_sh_init[j];
        end else if (ce && r_act_ffen[j]) begin
          r_ff[j] <= w_f[j];
        end
      end
    end
  end

  // Zero padding makes out-of-range input selects read constant 0
  assign w_din_pad = DPAD'(r_din_q);

  for (genvar j = 0; j < NUM_LUT; j++) begin : g_lut
    logic [LUT_K-1:0] w_idx;

    for (genvar i = 0; i < LUT_K; i++) begin : g_sel
      logic [SW-1:0] w_sel;
      assign w_sel    = r_act_sel[j][i*SW +: SW];
      assign w_idx[i] = w_din_pad[w_sel];
    end

    clb_lut #(
      .LUT_K (LUT_K)
    ) u_lut (
      .i_mask (r_act_mask[j]),
      .i_in   (w_idx),
      .o_f    (w_f[j])
    );

    assign w_stage[j] = r_act_ffen[j] ? r_ff[j] : w_f[j];
  end

  // Zero padding makes out-of-range output selects read constant 0
  assign w_stage_pad = SPAD'(w_stage);

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_out
    assign dout[n] = w_stage_pad[r_act_osel[n]];
  end

  assign cfg_dout  = r_shadow[CFG_BITS-1];
  assign cfg_valid = r_valid;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_clb_param.sv
module tb_clb_param;

  localparam int NI = 4;
  localparam int K  = 3;
  localparam int NL = 2;
  localparam int NO = 2;
  localparam int SW = 2;
  localparam int OW = 1;
  localparam int LF = 16;
  localparam int CB = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          d_rstn;
  logic [NI-1:0] d_din;
  logic          d_ce;
  logic          d_en;
  logic          d_cbit;
  logic          d_commit;
  logic          cfg_dout;
  logic          cfg_valid;
  logic          cfg_err;
  logic [NO-1:0] dout;

  clb_param #(
    .NUM_IN  (NI),
    .LUT_K   (K),
    .NUM_LUT (NL),
    .NUM_OUT (NO)
  ) dut (
    .clk        (clk),
    .reset_n    (d_rstn),
    .din        (d_din),
    .ce         (d_ce),
    .cfg_en     (d_en),
    .cfg_din    (d_cbit),
    .cfg_commit (d_commit),
    .cfg_dout   (cfg_dout),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err),
    .dout       (dout)
  );

  // Reference model state
  int            a_sel  [NL][K];
  int            a_mask [NL];
  bit            a_ffen [NL];
  int            a_osel [NO];
  logic [CB-1:0] m_shadow;
  logic [NI-1:0] m_dinq;
  logic [NL-1:0] m_r;
  bit            m_valid;
  bit            m_err;
  bit            m_loading;
  int            m_count;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void load_active(input logic [CB-1:0] v);
    for (int j = 0; j < NL; j++) begin
      for (int i = 0; i < K; i++) a_sel[j][i] = int'(v[j*LF + i*SW +: SW]);
      a_mask[j] = int'(v[j*LF + K*SW +: 8]);
      a_ffen[j] = v[j*LF + K*SW + 8];
    end
    for (int n = 0; n < NO; n++) a_osel[n] = int'(v[NL*LF + n*OW +: OW]);
  endfunction

  function automatic bit lut_f(input int j);
    int idx;
    idx = 0;
    for (int i = 0; i < K; i++)
      if (a_sel[j][i] < NI && m_dinq[a_sel[j][i]] == 1'b1) idx += (1 << i);
    return a_mask[j][idx];
  endfunction

  function automatic logic [NO-1:0] m_dout();
    logic [NL-1:0] st;
    logic [NO-1:0] o;
    for (int j = 0; j < NL; j++) st[j] = a_ffen[j] ? m_r[j] : lut_f(j);
    for (int n = 0; n < NO; n++) o[n] = (a_osel[n] < NL) ? st[a_osel[n]] : 1'b0;
    return o;
  endfunction

  function automatic logic [LF-1:0] enc_lut(input int s0, input int s1, input int s2,
                                            input logic [7:0] mask, input bit ffen,
                                            input bit finit);
    return {finit, ffen, mask, 2'(s2), 2'(s1), 2'(s0)};
  endfunction

  function automatic logic [CB-1:0] enc_cfg(input logic [LF-1:0] l0, input logic [LF-1:0] l1,
                                            input logic o0, input logic o1);
    return {o1, o0, l1, l0};
  endfunction

  // One clock edge: advance the model from the pre-edge inputs, then settle
  task automatic tick();
    logic [NL-1:0] f;
    bit ok;
    bit entry;
    @(posedge clk);
    if (!d_rstn) begin
      m_shadow  = '0;
      load_active('0);
      m_valid   = 0;
      m_err     = 0;
      m_dinq    = '0;
      m_r       = '0;
      m_loading = 0;
      m_count   = 0;
    end else begin
      for (int j = 0; j < NL; j++) f[j] = lut_f(j);
      ok    = d_commit && m_loading && (m_count == CB);
      entry = d_en && !m_loading;
      if (ok) begin
        for (int j = 0; j < NL; j++) m_r[j] = m_shadow[j*LF + LF - 1];
        load_active(m_shadow);
        m_valid = 1;
      end else if (d_ce) begin
        for (int j = 0; j < NL; j++) if (a_ffen[j]) m_r[j] = f[j];
      end
      if (d_commit && !ok) m_err = 1;
      else if (entry) m_err = 0;
      m_dinq = d_din;
      if (d_en) begin
        m_shadow = {m_shadow[CB-2:0], d_cbit};
        if (entry || d_commit) m_count = 1;
        else if (m_count < CB) m_count++;
        m_loading = 1;
      end else if (d_commit) begin
        m_loading = 0;
        m_count   = 0;
      end
    end
    #1;
  endtask

  task automatic shift_vec(input logic [CB-1:0] v);
    for (int b = CB - 1; b >= 0; b--) begin
      d_en   = 1'b1;
      d_cbit = v[b];
      tick();
    end
    d_en   = 1'b0;
    d_cbit = 1'b0;
  endtask

  task automatic do_commit();
    d_commit = 1'b1;
    tick();
    d_commit = 1'b0;
  endtask

  task automatic test_reset();
    d_rstn = 0; d_din = '0; d_ce = 0; d_en = 0; d_cbit = 0; d_commit = 0;
    tick();
    tick();
    n_cmp++; if (dout !== 2'b00) begin n_bad++; $display("FAIL reset_dout: got %b expected 00", dout); end
    n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", cfg_valid); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
    n_cmp++; if (cfg_dout !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_dout: got %b expected 0", cfg_dout); end
    d_rstn = 1;
    tick();
  endtask

  task automatic test_comb_and();
    logic [CB-1:0] v;
    v = enc_cfg(enc_lut(0, 1, 2, 8'h80, 0, 0), enc_lut(0, 0, 0, 8'h00, 0, 0), 1'b0, 1'b0);
    d_din = '0;
    shift_vec(v);
    do_commit();
    n_cmp++; if (cfg_valid !== 1'b1) begin n_bad++; $display("FAIL and_valid: got %b expected 1", cfg_valid); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL and_err: got %b expected 0", cfg_err); end
    d_din = 4'b0111;
    tick();
    n_cmp++; if (dout[0] !== 1'b1) begin n_bad++; $display("FAIL and_0111: got %b expected 1", dout[0]); end
    n_cmp++; if (dout !== m_dout()) begin n_bad++; $display("FAIL and_model: got %b expected %b", dout, m_dout()); end
    d_din = 4'b0011;
    tick();
    n_cmp++; if (dout[0] !== 1'b0) begin n_bad++; $display("FAIL and_0011: got %b expected 0", dout[0]); end
  endtask

  task automatic test_ff_mode();
    logic [CB-1:0] v;
    v = enc_cfg(enc_lut(0, 1, 2, 8'h80, 1, 1), enc_lut(0, 0, 0, 8'h00, 0, 0), 1'b0, 1'b0);
    d_din = '0;
    d_ce  = 1;
    shift_vec(v);
    do_commit();
    n_cmp++; if (dout[0] !== 1'b1) begin n_bad++; $display("FAIL ff_init: got %b expected 1", dout[0]); end
    d_ce = 0;
    repeat (3) tick();
    n_cmp++; if (dout[0] !== 1'b1) begin n_bad++; $display("FAIL ff_hold: got %b expected 1", dout[0]); end
    d_ce = 1;
    tick();
    tick();
    n_cmp++; if (dout[0] !== 1'b0) begin n_bad++; $display("FAIL ff_clear: got %b expected 0", dout[0]); end
    d_din = 4'b0111;
    tick();
    n_cmp++; if (dout[0] !== 1'b0) begin n_bad++; $display("FAIL ff_lat1: got %b expected 0", dout[0]); end
    tick();
    n_cmp++; if (dout[0] !== 1'b1) begin n_bad++; $display("FAIL ff_lat2: got %b expected 1", dout[0]); end
    n_cmp++; if (dout !== m_dout()) begin n_bad++; $display("FAIL ff_model: got %b expected %b", dout, m_dout()); end
  endtask

  task automatic test_short_load();
    logic [CB-1:0] v;
    logic [NO-1:0] saved;
    d_ce  = 0;
    saved = dout;
    v = CB'({$urandom(), $urandom()});
    for (int b = CB - 1; b >= 1; b--) begin
      d_en   = 1'b1;
      d_cbit = v[b];
      tick();
    end
    d_en = 1'b0;
    do_commit();
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL short_err: got %b expected 1", cfg_err); end
    n_cmp++; if (cfg_valid !== 1'b1) begin n_bad++; $display("FAIL short_valid: got %b expected 1", cfg_valid); end
    n_cmp++; if (dout !== saved) begin n_bad++; $display("FAIL short_dout: got %b expected %b", dout, saved); end
    d_en   = 1'b1;
    d_cbit = 1'b0;
    tick();
    d_en = 1'b0;
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL short_err_clear: got %b expected 0", cfg_err); end
    do_commit();
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL short_err_again: got %b expected 1", cfg_err); end
  endtask

  task automatic test_reload();
    logic [CB-1:0] v_and;
    logic [CB-1:0] v_or;
    logic [NI-1:0] cur;
    v_and = enc_cfg(enc_lut(0, 1, 2, 8'h80, 0, 0), enc_lut(0, 0, 0, 8'h00, 0, 0), 1'b0, 1'b0);
    v_or  = enc_cfg(enc_lut(0, 1, 2, 8'hFE, 0, 0), enc_lut(0, 0, 0, 8'h00, 0, 0), 1'b0, 1'b0);
    d_ce = 1;
    shift_vec(v_and);
    do_commit();
    for (int b = CB - 1; b >= 0; b--) begin
      cur    = NI'($urandom());
      d_din  = cur;
      d_en   = 1'b1;
      d_cbit = v_or[b];
      tick();
      n_cmp++;
      if (dout[0] !== (&cur[2:0])) begin
        n_bad++; $display("FAIL reload_and bit%0d: got %b expected %b", b, dout[0], &cur[2:0]);
      end
    end
    d_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cur      = NI'($urandom());
      d_din    = cur;
      d_commit = (c == 0);
      tick();
      n_cmp++;
      if (dout[0] !== (|cur[2:0])) begin
        n_bad++; $display("FAIL reload_or c%0d: got %b expected %b", c, dout[0], |cur[2:0]);
      end
    end
    d_commit = 1'b0;
  endtask

  task automatic test_overshift();
    bit            seq [1:40];
    logic [CB-1:0] v;
    logic [NI-1:0] cur;
    v = enc_cfg(enc_lut(0, 1, 2, 8'h96, 0, 0), enc_lut(3, 3, 1, 8'h3C, 0, 0), 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) seq[k] = bit'($urandom_range(0, 1));
    for (int k = 7; k <= 40; k++) seq[k] = v[40 - k];
    for (int k = 1; k <= 40; k++) begin
      d_en   = 1'b1;
      d_cbit = seq[k];
      tick();
      if (k >= 34 && k <= 39) begin
        n_cmp++;
        if (cfg_dout !== seq[k-33]) begin
          n_bad++; $display("FAIL over_cfg_dout k%0d: got %b expected %b", k, cfg_dout, seq[k-33]);
        end
      end
    end
    d_en = 1'b0;
    do_commit();
    n_cmp++; if (cfg_valid !== 1'b1) begin n_bad++; $display("FAIL over_valid: got %b expected 1", cfg_valid); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL over_err: got %b expected 0", cfg_err); end
    for (int c = 0; c < 8; c++) begin
      cur   = NI'($urandom());
      d_din = cur;
      tick();
      n_cmp++;
      if (dout[0] !== (^cur[2:0])) begin
        n_bad++; $display("FAIL over_xor c%0d: got %b expected %b", c, dout[0], ^cur[2:0]);
      end
      n_cmp++;
      if (dout !== m_dout()) begin
        n_bad++; $display("FAIL over_model c%0d: got %b expected %b", c, dout, m_dout());
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [CB-1:0] v;
    logic [NI-1:0] cur;
    for (int k = 0; k < 20; k++) begin
      d_en   = 1'b1;
      d_cbit = 1'b1;
      tick();
    end
    d_en     = 1'b0;
    d_rstn   = 1'b0;
    d_commit = 1'b1;
    tick();
    d_commit = 1'b0;
    n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b expected 0", cfg_valid); end
    n_cmp++; if (dout !== 2'b00) begin n_bad++; $display("FAIL rmid_dout: got %b expected 00", dout); end
    n_cmp++; if (cfg_dout !== 1'b0) begin n_bad++; $display("FAIL rmid_cfg_dout: got %b expected 0", cfg_dout); end
    d_rstn = 1'b1;
    tick();
    v = enc_cfg(enc_lut(0, 1, 2, 8'h80, 0, 0), enc_lut(0, 1, 2, 8'hFE, 0, 0), 1'b0, 1'b1);
    shift_vec(v);
    do_commit();
    n_cmp++; if (cfg_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_reload_valid: got %b expected 1", cfg_valid); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rmid_reload_err: got %b expected 0", cfg_err); end
    for (int c = 0; c < 6; c++) begin
      cur   = NI'($urandom());
      d_din = cur;
      tick();
      n_cmp++;
      if (dout !== {|cur[2:0], &cur[2:0]}) begin
        n_bad++; $display("FAIL rmid_func c%0d: got %b expected %b", c, dout, {|cur[2:0], &cur[2:0]});
      end
    end
  endtask

  task automatic test_random();
    logic [CB-1:0] v;
    for (int it = 0; it < 8; it++) begin
      v = CB'({$urandom(), $urandom()});
      for (int b = CB - 1; b >= 0; b--) begin
        d_din  = NI'($urandom());
        d_ce   = 1'($urandom());
        d_en   = 1'b1;
        d_cbit = v[b];
        tick();
        n_cmp++;
        if (dout !== m_dout() || cfg_dout !== m_shadow[CB-1]) begin
          n_bad++;
          $display("FAIL rand_load it%0d b%0d: got dout=%b cfg_dout=%b expected dout=%b cfg_dout=%b",
                   it, b, dout, cfg_dout, m_dout(), m_shadow[CB-1]);
        end
      end
      d_en = 1'b0;
      do_commit();
      n_cmp++;
      if (cfg_valid !== m_valid || cfg_err !== m_err) begin
        n_bad++;
        $display("FAIL rand_commit it%0d: got valid=%b err=%b expected valid=%b err=%b",
                 it, cfg_valid, cfg_err, m_valid, m_err);
      end
      for (int c = 0; c < 20; c++) begin
        d_din = NI'($urandom());
        d_ce  = 1'($urandom());
        tick();
        n_cmp++;
        if (dout !== m_dout()) begin
          n_bad++; $display("FAIL rand_run it%0d c%0d: got %b expected %b", it, c, dout, m_dout());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_comb_and();
    test_ff_mode();
    test_short_load();
    test_reload();
    test_overshift();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clb_param.md
CLB_PARAM -- requirements
Module: clb_param

Interface
REQ-001 Parameter NUM_IN, default 4: number of primary logic inputs (>=2).
REQ-002 Parameter LUT_K, default 3: inputs per LUT (1..6).
REQ-003 Parameter NUM_LUT, default 2: number of LUTs (>=1).
REQ-004 Parameter NUM_OUT, default 2: number of primary outputs (>=1).
REQ-005 Derived constants: SW = max(1,clog2(NUM_IN)); OW = max(1,clog2(NUM_LUT)); LF = LUT_K*SW + 2^LUT_K + 2; CFG_BITS = NUM_LUT*LF + NUM_OUT*OW (34 at defaults).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 din  in  NUM_IN  logic inputs.
REQ-009 ce  in  1  clock enable for LUT flip-flops.
REQ-010 cfg_en  in  1  shift one config bit this cycle.
REQ-011 cfg_din  in  1  serial config data.
REQ-012 cfg_commit  in  1  request shadow-to-active transfer.
REQ-013 cfg_dout  out  1  shadow MSB, for daisy-chaining.
REQ-014 cfg_valid  out  1  active configuration loaded.
REQ-015 cfg_err  out  1  sticky: commit attempted with incomplete load.
REQ-016 dout  out  NUM_OUT  logic outputs.

Function
REQ-017 Shadow register CFG_BITS wide; on cfg_en it shifts left, cfg_din enters bit 0; cfg_dout = shadow[CFG_BITS-1].
REQ-018 Field layout: LUT j at [j*LF +: LF] = {ff_init, ff_en, mask[2^K-1:0], sel[K*SW-1:0]}, sel i at [i*SW +: SW]; output n select at [NUM_LUT*LF + n*OW +: OW].
REQ-019 FSM states IDLE, LOAD. IDLE->LOAD on cfg_en; LOAD->IDLE on cfg_commit; shift counter cleared on IDLE->LOAD entry and then counts shifts, saturating at CFG_BITS.
REQ-020 Commit with counter == CFG_BITS (including the entry shift): active config <= shadow, cfg_valid <= 1, LUT FFs load ff_init next edge, cfg_err unchanged.
REQ-021 Commit with counter != CFG_BITS, or in IDLE: active config unchanged, cfg_err <= 1; FSM returns to IDLE.
REQ-022 cfg_en and cfg_commit same cycle: commit evaluated on pre-shift shadow and count; shift also occurs and FSM enters LOAD with counter = 1.
REQ-023 cfg_err clears only on reset or on IDLE->LOAD entry.
REQ-024 Active config keeps operating during LOAD; no glitch until commit.
REQ-025 Input stage: din registered every cycle into din_q.
REQ-026 LUT j output f[j] = mask[{din_q[sel[K-1]],...,din_q[sel[0]]}]; sel value >= NUM_IN selects constant 0.
REQ-027 LUT j registered path: if ff_en, r[j] <= f[j] when ce; stage value = ff_en ? r[j] : f[j].
REQ-028 dout[n] = stage value of LUT indexed by output select; index >= NUM_LUT yields 0.
REQ-029 Latency din->dout: 1 cycle combinational mode, 2 cycles (ce high) FF mode.

Reset
REQ-030 reset_n low: shadow, active config, counter, din_q, r[] = 0; FSM IDLE; cfg_valid = 0; cfg_err = 0; hence dout = 0, cfg_dout = 0.
REQ-031 Reset mid-LOAD discards partial shadow; reset overrides same-cycle commit.

Structure
REQ-032 Package clb_pkg holds FSM state enum and functions computing SW, OW, LF, CFG_BITS.
REQ-033 Sub-module clb_lut: parametrised LUT_K-input LUT, combinational, mask and input vector ports.

Verification
REQ-034 Shift 34 bits making LUT0 sel={2,1,0}, mask=8'h80, ff_en=0, out0 sel=0; commit; din=4'b0111 -> dout[0]=1 one cycle later; din=4'b0011 -> dout[0]=0.
REQ-035 Same load with ff_en=1, ff_init=1: dout[0]=1 right after commit; ce=0 holds value; ce=1, din=0 -> dout[0]=0 after 2 cycles.
REQ-036 Shift 33 bits then commit -> cfg_err=1, cfg_valid unchanged, dout unchanged; next cfg_en clears cfg_err.
REQ-037 Active config running AND; reload OR mask 8'hFE over 34 cycles -> dout follows AND until commit cycle, OR thereafter.
REQ-038 Shift 40 bits -> cfg_dout reproduces bits 1..6 shifted in; counter saturated, commit succeeds with last 34 bits.
REQ-039 reset_n low after 20 shifts -> cfg_valid=0, dout=0; subsequent 34-bit load commits cleanly.
